// File: rtl/led_matrix_spi_rx.sv
// led_matrix_spi_rx: sysclk-oversampled SPI receiver for 16-bit address/data
// frames, decoding into a row-register file and display control registers.
// Optional feature macro: LED_MATRIX_RX_DOUT_EN adds the spi_dout daisy-chain output.
module led_matrix_spi_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_ROWS    = 8
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  input  logic [2:0] row_sel,
  output logic [7:0] row_data,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [3:0] frame_addr,
  output logic [7:0] frame_data,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown_n,
`ifdef LED_MATRIX_RX_DOUT_EN
  output logic       display_test,
  output logic       spi_dout
`else
  output logic       display_test
`endif
);

  localparam int unsigned CNT_W      = 5;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(16);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(17);
  localparam logic [3:0] ADDR_DECODE = 4'h9;
  localparam logic [3:0] ADDR_INTENS = 4'hA;
  localparam logic [3:0] ADDR_SCAN   = 4'hB;
  localparam logic [3:0] ADDR_SHDN   = 4'hC;
  localparam logic [3:0] ADDR_TEST   = 4'hF;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] clk_sync, cs_sync, mosi_sync;
  logic                   clk_d, cs_d;
  logic                   clk_s, cs_s, mosi_s;
  logic                   clk_rise, clk_fall, cs_rise, cs_fall;
  logic                   shift_en, close_en, clear_cnt;
  logic                   accept, reject;
  logic [15:0]            sr;
  logic [CNT_W-1:0]       cnt;
  logic [7:0]             rows [NUM_ROWS];
  logic                   unused_bits;

  // Synchronise SPI pins into sysclk and keep one delayed copy for edge detect.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      clk_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      clk_d     <= clk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_d;
  assign clk_fall = ~clk_s & clk_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  // FSM state register.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a clock edge coinciding with frame close is dropped.
  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    close_en  = 1'b0;
    clear_cnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = SHIFT;
          clear_cnt = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d  = IDLE;
          close_en = 1'b1;
        end else if (clk_rise) begin
          shift_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = close_en & (cnt == CNT_FULL);
  assign reject = close_en & (cnt != CNT_FULL);

  // Shift register and saturating bit counter.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else begin
      if (shift_en) sr <= {sr[14:0], mosi_s};
      if (clear_cnt)                       cnt <= '0;
      else if (shift_en && cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
    end
  end

  // Frame status pulses and captured fields of the last accepted frame.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_addr  <= '0;
      frame_data  <= '0;
    end else begin
      frame_valid <= accept;
      frame_err   <= reject;
      if (accept) begin
        frame_addr <= sr[11:8];
        frame_data <= sr[7:0];
      end
    end
  end

  // Control register decode on an accepted frame.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
    end else if (accept) begin
      case (sr[11:8])
        ADDR_DECODE: decode_mode  <= sr[7:0];
        ADDR_INTENS: intensity    <= sr[3:0];
        ADDR_SCAN:   scan_limit   <= sr[2:0];
        ADDR_SHDN:   shutdown_n   <= sr[0];
        ADDR_TEST:   display_test <= sr[0];
        default: ;
      endcase
    end
  end

  // Row register file; address i+1 selects row i.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ROWS; i++) rows[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        if (sr[11:8] == 4'(i + 1)) rows[i] <= sr[7:0];
      end
    end
  end

  // Combinational row read; unmapped rows read as zero.
  always_comb begin
    row_data = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (row_sel == 3'(i)) row_data = rows[i];
    end
  end

`ifdef LED_MATRIX_RX_DOUT_EN
  logic out_bit;

  // Daisy-chain output: the MSB pushed out on a rising edge is driven on the next falling edge.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      out_bit  <= 1'b0;
      spi_dout <= 1'b0;
    end else begin
      if (shift_en) out_bit <= sr[15];
      if (state_q == SHIFT && clk_fall && !cs_rise) spi_dout <= out_bit;
    end
  end
`endif

  assign unused_bits = ^sr[15:12];

endmodule

// File: tb/tb_led_matrix_spi_rx.sv
// tb_led_matrix_spi_rx: scoreboard bench for led_matrix_spi_rx with directed frames.
// Optional feature macro: LED_MATRIX_RX_DOUT_EN enables the spi_dout sequence check.
module tb_led_matrix_spi_rx;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       spi_clk, spi_cs_n, spi_mosi;
  logic [2:0] row_sel;
  logic [7:0] row_data;
  logic       frame_valid, frame_err;
  logic [3:0] frame_addr;
  logic [7:0] frame_data;
  logic [7:0] decode_mode;
  logic [3:0] intensity;
  logic [2:0] scan_limit;
  logic       shutdown_n, display_test;
`ifdef LED_MATRIX_RX_DOUT_EN
  logic       spi_dout;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         err;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic [15:0] dout_seq;

  led_matrix_spi_rx dut (
    .sysclk(sysclk), .reset(reset),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .row_sel(row_sel), .row_data(row_data),
    .frame_valid(frame_valid), .frame_err(frame_err),
    .frame_addr(frame_addr), .frame_data(frame_data),
    .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
`ifdef LED_MATRIX_RX_DOUT_EN
    .shutdown_n(shutdown_n), .display_test(display_test), .spi_dout(spi_dout)
`else
    .shutdown_n(shutdown_n), .display_test(display_test)
`endif
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // One SPI bit: low phase with data set up, high phase, then low settle.
  task automatic clk_bit(input logic b);
    spi_mosi = b;
    wait_cyc(4);
    spi_clk = 1'b1;
    wait_cyc(4);
    spi_clk = 1'b0;
    wait_cyc(4);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      wait_cyc(1);
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Send n bits of v MSB first in one cs_n window and record spi_dout after each fall.
  task automatic spi_frame(input logic [31:0] v, input int n, input bit err, output logic [15:0] cap);
    exp_t e;
    cap = '0;
    spi_cs_n = 1'b0;
    wait_cyc(4);
    for (int i = n - 1; i >= 0; i--) begin
      clk_bit(v[i]);
`ifdef LED_MATRIX_RX_DOUT_EN
      cap = {cap[14:0], spi_dout};
`endif
    end
    e.err  = err;
    e.addr = v[11:8];
    e.data = v[7:0];
    exp_q.push_back(e);
    spi_cs_n = 1'b1;
    wait_cyc(8);
    drain();
  endtask

  task automatic check_row(input int r, input logic [7:0] e);
    row_sel = 3'(r);
    #1;
    check($sformatf("row%0d", r), 32'(row_data), 32'(e));
  endtask

  // Monitor: every frame pulse is matched against the next scoreboard entry.
  always @(negedge sysclk) begin
    if (frame_valid || frame_err) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected no pulse", frame_valid, frame_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, frame_valid, frame_err}, e.err ? 32'd1 : 32'd2);
        if (!e.err) begin
          check("frame_addr", 32'(frame_addr), 32'(e.addr));
          check("frame_data", 32'(frame_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; row_sel = '0;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(5);

    // Reset state
    for (int r = 0; r < 8; r++) check_row(r, 8'h00);
    check("rst_shutdown_n", 32'(shutdown_n), 0);
    check("rst_intensity", 32'(intensity), 0);
    check("rst_valid", 32'(frame_valid), 0);
    check("rst_err", 32'(frame_err), 0);

    // Control registers
    spi_frame(32'h0C01, 16, 1'b0, dout_seq);
    spi_frame(32'h0A07, 16, 1'b0, dout_seq);
    check("shutdown_n_on", 32'(shutdown_n), 1);
    check("intensity_7", 32'(intensity), 7);
    check("last_addr", 32'(frame_addr), 32'hA);
    check("last_data", 32'(frame_data), 32'h07);

    // First and last rows
    spi_frame(32'h0155, 16, 1'b0, dout_seq);
    spi_frame(32'h08AA, 16, 1'b0, dout_seq);
    check_row(0, 8'h55);
    check_row(7, 8'hAA);
    for (int r = 1; r < 7; r++) check_row(r, 8'h00);

    // Short and long frames are rejected
    spi_frame(32'h0355, 15, 1'b1, dout_seq);
    spi_frame(32'h00355, 17, 1'b1, dout_seq);
    check_row(2, 8'h00);

    // Unused address and ignored upper nibble
    spi_frame(32'h0D3C, 16, 1'b0, dout_seq);
    spi_frame(32'hF1FF, 16, 1'b0, dout_seq);
    check_row(0, 8'hFF);
    check_row(7, 8'hAA);
    check("decode_keep", 32'(decode_mode), 0);
    check("scan_keep", 32'(scan_limit), 0);
    check("test_keep", 32'(display_test), 0);
    check("intens_keep", 32'(intensity), 7);
    check("shdn_keep", 32'(shutdown_n), 1);

    spi_frame(32'h0993, 16, 1'b0, dout_seq);
    spi_frame(32'h0F01, 16, 1'b0, dout_seq);
    check("decode_mode", 32'(decode_mode), 32'h93);
    check("display_test", 32'(display_test), 1);

    // Reset after bit 9 of frame 0x0B05, held through cs_n rise
    spi_cs_n = 1'b0;
    wait_cyc(4);
    for (int i = 15; i >= 7; i--) clk_bit(1'((16'h0B05 >> i) & 16'h1));
    reset = 1'b1;
    wait_cyc(3);
    for (int i = 6; i >= 0; i--) clk_bit(1'((16'h0B05 >> i) & 16'h1));
    spi_cs_n = 1'b1;
    wait_cyc(10);
    reset = 1'b0;
    wait_cyc(12);
    check("mid_rst_scan", 32'(scan_limit), 0);
    check("mid_rst_shdn", 32'(shutdown_n), 0);
    check("mid_rst_addr", 32'(frame_addr), 0);
    check_row(0, 8'h00);

    spi_frame(32'h0B05, 16, 1'b0, dout_seq);
    check("scan_limit_5", 32'(scan_limit), 5);

`ifdef LED_MATRIX_RX_DOUT_EN
    spi_frame(32'h8001, 16, 1'b0, dout_seq);
    spi_frame(32'h0000, 16, 1'b0, dout_seq);
    check("dout_seq", 32'(dout_seq), 32'h8001);
`endif

    wait_cyc(10);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
